fifo_word_packer: RTL and testbench

//  Downstream consumer of the 8-bit x16 sync FIFO (clk/rst/din/wr_en/rd_en/dout/full/empty/valid).

---
 rtl/fifo_word_packer.sv | 134 +++++++++++++
 tb/tb_fifo_word_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Pops bytes from a 1-cycle-latency sync FIFO and packs BYTES_PER_WORD of them (first byte in LSBs)
// into a word presented on a valid/ready handshake. Define PACKER_TIMEOUT_FLUSH_EN for partial flush.
module fifo_word_packer #(
    parameter int unsigned DIN_W          = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYC    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIN_W-1:0]                fifo_dout,
    input  logic                            fifo_empty,
    input  logic                            fifo_valid,
    output logic                            fifo_rd_en,
    output logic [DIN_W*BYTES_PER_WORD-1:0] word_out,
    output logic [3:0]                      word_bytes,
    output logic                            word_valid,
    input  logic                            word_ready
);

    localparam int unsigned WordW = DIN_W * BYTES_PER_WORD;
    localparam logic [3:0]  Bpw   = 4'(BYTES_PER_WORD);

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("fifo_word_packer: illegal parameter set");
    end

    typedef enum logic {StFill, StOut} state_e;

    state_e             state_q, state_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic               inflight_q;
    logic [WordW-1:0]   lanes_q, lanes_d;
    logic [3:0]         word_bytes_q, word_bytes_d;
    logic               word_valid_q, word_valid_d;
    logic               capture;

    // A byte counts only if we asked for it last cycle; stray fifo_valid is dropped.
    assign capture = (state_q == StFill) && inflight_q && fifo_valid;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != StFill || capture) begin
            idle_cnt_d = '0;
        end else if (32'(idle_cnt_q) < TIMEOUT_CYC) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    // True in the TIMEOUT_CYC-th consecutive cycle without a captured byte.
    assign timeout = (state_q == StFill) && (byte_cnt_q != 4'd0) && !capture && !inflight_q &&
                     ((32'(idle_cnt_q) + 32'd1) >= TIMEOUT_CYC);
`endif

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        lanes_d      = lanes_q;
        word_bytes_d = word_bytes_q;
        word_valid_d = word_valid_q;
        fifo_rd_en   = 1'b0;

        case (state_q)
            StFill: begin
                // Reserve a lane for the byte already in flight so we never over-read.
                fifo_rd_en = !fifo_empty && ((byte_cnt_q + {3'b000, inflight_q}) < Bpw);
                if (capture) begin
                    for (int k = 0; k < BYTES_PER_WORD; k++) begin
                        if (byte_cnt_q == 4'(k)) begin
                            lanes_d[k*DIN_W +: DIN_W] = fifo_dout;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == Bpw - 4'd1) begin
                        state_d      = StOut;
                        word_valid_d = 1'b1;
                        word_bytes_d = Bpw;
                    end
                end
`ifdef PACKER_TIMEOUT_FLUSH_EN
                else if (timeout) begin
                    state_d      = StOut;
                    word_valid_d = 1'b1;
                    word_bytes_d = byte_cnt_q;
                end
`endif
            end
            StOut: begin
                if (word_ready) begin
                    state_d      = StFill;
                    word_valid_d = 1'b0;
                    word_bytes_d = 4'd0;
                    byte_cnt_d   = 4'd0;
                    lanes_d      = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFill;
            byte_cnt_q   <= 4'd0;
            inflight_q   <= 1'b0;
            lanes_q      <= '0;
            word_bytes_q <= 4'd0;
            word_valid_q <= 1'b0;
`ifdef PACKER_TIMEOUT_FLUSH_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            inflight_q   <= fifo_rd_en;
            lanes_q      <= lanes_d;
            word_bytes_q <= word_bytes_d;
            word_valid_q <= word_valid_d;
`ifdef PACKER_TIMEOUT_FLUSH_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign word_out   = lanes_q;
    assign word_bytes = word_bytes_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural byte FIFO plus a byte-stream-to-word reference model.
module tb_fifo_word_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_valid;
    logic        fifo_rd_en;
    logic [31:0] word_out;
    logic [3:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;

    fifo_word_packer #(
        .DIN_W         (8),
        .BYTES_PER_WORD(4),
        .TIMEOUT_CYC   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid),
        .fifo_rd_en(fifo_rd_en),
        .word_out  (word_out),
        .word_bytes(word_bytes),
        .word_valid(word_valid),
        .word_ready(word_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int n_valid = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  acc[$];
    logic [31:0] exp_w[$];
    int          exp_n[$];
    logic [35:0] held;
    bit          hold_chk = 0;
    logic [31:0] last_word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference model: every 4 pushed bytes form one word, first byte in the LSBs.
    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
        acc.push_back(b);
        if (acc.size() == 4) begin
            exp_w.push_back({acc[3], acc[2], acc[1], acc[0]});
            exp_n.push_back(4);
            acc.delete();
        end
    endtask

    // One clock: sample mid-cycle, then advance the FIFO model just after the edge.
    task automatic step(input bit spur);
        logic rd;
        #4;
        rd = fifo_rd_en;
        if (fifo_valid) n_valid++;
        if (word_valid) begin
            chk("rd_en_low_in_out", {63'd0, fifo_rd_en}, 64'd0);
            if (hold_chk) chk("word_held", {28'd0, word_bytes, word_out}, {28'd0, held});
            held     = {word_bytes, word_out};
            hold_chk = !word_ready;
            if (word_ready) begin
                if (exp_w.size() == 0) begin
                    chk("unexpected_word", {63'd0, word_valid}, 64'd0);
                end else begin
                    last_word = exp_w.pop_front();
                    chk("word_out", {32'd0, word_out}, {32'd0, last_word});
                    chk("word_bytes", {60'd0, word_bytes}, 64'(exp_n.pop_front()));
                end
            end
        end else begin
            hold_chk = 0;
        end
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) begin
            fifo_dout  = fifo_q.pop_front();
            fifo_valid = 1'b1;
        end else begin
            fifo_dout  = 8'($urandom);
            fifo_valid = spur && !rd;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic wait_valid(input int target, input int maxc, input string tag);
        int n = 0;
        while (n_valid < target && n < maxc) begin
            step(0);
            n++;
        end
        chk(tag, 64'(n_valid), 64'(target));
    endtask

    task automatic drain(input int maxc, input string tag);
        int n = 0;
        while (exp_w.size() > 0 && n < maxc) begin
            step(0);
            n++;
        end
        chk(tag, 64'(exp_w.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, {63'd0, fifo_rd_en}, 64'd0);
        chk({tag, "_valid"}, {63'd0, word_valid}, 64'd0);
        chk({tag, "_word"}, {32'd0, word_out}, 64'd0);
        chk({tag, "_bytes"}, {60'd0, word_bytes}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        fifo_dout  = 8'd0;
        fifo_empty = 1'b1;
        fifo_valid = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(0);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Single word, including capture-to-valid latency of one cycle.
        word_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid(n_valid + 4, 20, "t1_bytes_read");
        chk("t1_latency", {63'd0, word_valid}, 64'd1);
        chk("t1_word", {32'd0, word_out}, 64'h0403_0201);
        chk("t1_bytes", {60'd0, word_bytes}, 64'd4);
        step(0);
        repeat (5) begin
            step(0);
            chk("t1_rd_idle", {63'd0, fifo_rd_en}, 64'd0);
        end

        // Back-to-back stream of 16 bytes.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        drain(100, "t2_drained");
        chk("t2_last_word", {32'd0, last_word}, 64'h1F1E_1D1C);

        // Backpressure: first word held, nothing extra popped.
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        repeat (20) step(0);
        chk("t3_valid_held", {63'd0, word_valid}, 64'd1);
        chk("t3_fifo_level", 64'(fifo_q.size()), 64'd4);
        word_ready = 1'b1;
        drain(60, "t3_drained");

        // Partial word.
`ifdef PACKER_TIMEOUT_FLUSH_EN
        word_ready = 1'b0;
        push(8'h07); push(8'h0B); push(8'h13);
        exp_w.push_back({8'h00, acc[2], acc[1], acc[0]});
        exp_n.push_back(3);
        acc.delete();
        wait_valid(n_valid + 3, 20, "t4_bytes_read");
        repeat (14) step(0);
        chk("t4_no_early_flush", {63'd0, word_valid}, 64'd0);
        repeat (2) step(0);
        chk("t4_flush_valid", {63'd0, word_valid}, 64'd1);
        chk("t4_flush_word", {32'd0, word_out}, 64'h0013_0B07);
        chk("t4_flush_bytes", {60'd0, word_bytes}, 64'd3);
        word_ready = 1'b1;
        drain(10, "t4_drained");
`else
        push(8'h07); push(8'h0B); push(8'h13);
        repeat (100) begin
            step(0);
            chk("t4_no_flush", {63'd0, word_valid}, 64'd0);
        end
        rst = 1'b1;
        repeat (2) step(0);
        rst = 1'b0;
        acc.delete();
`endif

        // Reset with a partial word captured.
        push(8'($urandom)); push(8'($urandom));
        wait_valid(n_valid + 2, 20, "t5_bytes_read");
        step(0);
        rst = 1'b1;
        step(0);
        chk_reset_outputs("t5_in_reset");
        repeat (2) step(0);
        rst = 1'b0;
        acc.delete();
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        drain(20, "t5_drained");
        chk("t5_word", {32'd0, last_word}, 64'hA4A3_A2A1);

        // Empty FIFO with stray fifo_valid pulses.
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        repeat (100) begin
            step(($urandom_range(0, 3) == 0));
            chk("t6_rd_idle", {63'd0, fifo_rd_en}, 64'd0);
            chk("t6_valid_idle", {63'd0, word_valid}, 64'd0);
        end
        push(8'h5A); push(8'hC3); push(8'h3C); push(8'hA5);
        drain(20, "t6_drained");
        chk("t6_word", {32'd0, last_word}, 64'hA53C_C35A);

        // Random traffic with random backpressure and stray valids.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) push(8'($urandom));
            word_ready = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 4) == 0));
        end
        word_ready = 1'b1;
        for (int i = 0; i < 40 && acc.size() != 0; i++) begin
            if (fifo_q.size() < 16) push(8'($urandom));
            step(0);
        end
        drain(200, "t7_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
